// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, default constants and width helper for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam int DEF_ROWS          = 4;
    localparam int DEF_COLS          = 4;
    localparam int DEF_DWELL         = 2;
    localparam int DEF_DEBOUNCE      = 20;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_REPEAT_DELAY  = 500;
    localparam int DEF_REPEAT_PERIOD = 100;

    // Column synchroniser depth; a row's columns only show up this many cycles after it is driven.
    localparam int SYNC_STAGES = 2;

    // Bits needed to index n items, never less than one.
    function automatic int code_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// rtl/keypad_fifo.sv - show-ahead key code FIFO, push on full only succeeds with a same-cycle pop
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_pop;
    logic         do_push;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_q[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// rtl/matrix_keypad_scanner.sv - row-scanning keypad decoder with debounce and code FIFO; KEYPAD_AUTOREPEAT_EN adds auto-repeat
module matrix_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS          = DEF_ROWS,
    parameter int COLS          = DEF_COLS,
    parameter int DWELL         = DEF_DWELL,
    parameter int DEBOUNCE      = DEF_DEBOUNCE,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    localparam int CW           = code_width(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col_matrix,
    output logic [ROWS-1:0] lin_matrix,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            overflow,
    input  logic            clr_overflow
);

    // Rows are held long enough for DWELL synchronised samples of their own columns.
    localparam int DWL = SYNC_STAGES + DWELL;
    localparam int RW  = code_width(ROWS);
    localparam int CLW = code_width(COLS);
    localparam int DWW = code_width(DWL);
    localparam int DBW = code_width(DEBOUNCE);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (DWELL < 1) ||
        (DEBOUNCE < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
        $error("matrix_keypad_scanner: invalid parameter set");
    end

    logic [COLS-1:0] sync1;
    logic [COLS-1:0] col_sync;
    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d, next_row;
    logic [CLW-1:0]  col_q, col_d, low_idx;
    logic [DWW-1:0]  dwell_q, dwell_d;
    logic [DBW-1:0]  db_q, db_d;
    logic            col_hit;
    logic            any_low;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   new_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW  = code_width(RMAX + 1);
    logic [RPW-1:0] rep_q, rep_d;
    logic           rep_first_q, rep_first_d;
    logic [RPW-1:0] rep_target;
    assign rep_target = rep_first_q ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_PERIOD);
`endif

    assign lin_matrix = ~(ROWS'(1) << row_q);
    assign next_row   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    assign col_hit    = !col_sync[col_q];
    assign any_low    = |(~col_sync);
    assign new_code   = CW'(int'(row_q) * COLS + int'(col_q));
    assign pop        = key_valid && key_ready;
    assign key_valid  = !fifo_empty;

    // Two-flop synchroniser on the pulled-up column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '1;
            col_sync <= '1;
        end else begin
            sync1    <= col_matrix;
            col_sync <= sync1;
        end
    end

    // Lowest-index active column for the detection latch.
    always_comb begin
        low_idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!col_sync[i]) begin
                low_idx = CLW'(i);
            end
        end
    end

    // Scanner state, row/column latch and dwell/debounce/repeat counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SCAN;
            row_q   <= '0;
            col_q   <= '0;
            dwell_q <= '0;
            db_q    <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            db_q    <= db_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    // Next-state logic: scan, debounce press, hold, debounce release.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        db_d    = db_q;
        push    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWW'(DWL - 1)) begin
                    dwell_d = '0;
                    if (any_low) begin
                        state_d = ST_DEBOUNCE;
                        col_d   = low_idx;
                        db_d    = '0;
                    end else begin
                        row_d = next_row;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (col_hit) begin
                    if (db_q == DBW'(DEBOUNCE - 1)) begin
                        push    = 1'b1;
                        state_d = ST_HELD;
                        db_d    = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d       = '0;
                        rep_first_d = 1'b1;
`endif
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    state_d = ST_SCAN;
                    row_d   = next_row;
                    dwell_d = '0;
                    db_d    = '0;
                end
            end
            ST_HELD: begin
                if (!col_hit) begin
                    state_d = ST_RELEASE;
                    db_d    = '0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rep_q + 1'b1 == rep_target) begin
                    push        = 1'b1;
                    rep_d       = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                if (col_hit) begin
                    state_d = ST_HELD;
                    db_d    = '0;
                end else if (db_q == DBW'(DEBOUNCE - 1)) begin
                    state_d = ST_SCAN;
                    row_d   = next_row;
                    dwell_d = '0;
                    db_d    = '0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Sticky overflow: a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (new_code),
        .pop       (pop),
        .pop_data  (key_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/matrix_keypad_scanner.md
MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of driven keypad lines.
REQ-002 SHALL have parameter COLS, default 4, number of sensed keypad columns.
REQ-003 SHALL have parameter DWELL, default 2, cycles each row is driven before its columns are sampled.
REQ-004 SHALL have parameter DEBOUNCE, default 20, consecutive stable samples required for press and for release.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, buffered key codes (power of two, >=2).
REQ-006 SHALL have parameters REPEAT_DELAY (default 500) and REPEAT_PERIOD (default 100), auto-repeat timing in cycles.
REQ-007 clk  in  1  scan clock (1 kHz system tick).
REQ-008 rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-009 col_matrix  in  COLS  column sense, active-low, pulled up.
REQ-010 lin_matrix  out  ROWS  row drive, active-low one-hot.
REQ-011 key_code  out  CW=$clog2(ROWS*COLS)  FIFO head code, row*COLS+col.
REQ-012 key_valid  out  1  FIFO non-empty.
REQ-013 key_ready  in  1  consumer accepts head when key_valid && key_ready.
REQ-014 overflow  out  1  sticky: a code was dropped on full FIFO.
REQ-015 clr_overflow  in  1  synchronous clear of overflow.

Function
REQ-016 col_matrix SHALL pass a 2-flop synchroniser; all latencies below count from synchronised samples.
REQ-017 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-018 SCAN: drive row r for DWELL cycles; sample on last dwell cycle; no low column -> r advances, ROWS-1 wraps to 0.
REQ-019 SCAN, any column low at sample -> latch r and lowest-index low column, enter DEBOUNCE, keep row r driven.
REQ-020 DEBOUNCE: latched column SHALL read low for DEBOUNCE consecutive cycles; any high sample -> SCAN at next row, nothing pushed.
REQ-021 DEBOUNCE completion in cycle t SHALL push code; key_valid high in t+1 if FIFO was empty; state -> HELD.
REQ-022 HELD: latched column high -> RELEASE; RELEASE requires DEBOUNCE consecutive high samples -> SCAN (next row); any low sample -> HELD.
REQ-023 Other keys pressed while HELD/RELEASE SHALL be ignored.
REQ-024 FIFO show-ahead: key_code = head whenever key_valid; pop on key_valid && key_ready.
REQ-025 Push on full without same-cycle pop SHALL drop the code and set overflow; push+pop on full SHALL both succeed.
REQ-026 Push and pop on empty: push stored, no pop (key_valid was low).
REQ-027 clr_overflow and a new overflow in the same cycle: overflow stays 1.

Reset
REQ-028 rst SHALL immediately force: state SCAN, r=0, lin_matrix=~1 (row 0 low), FIFO empty, key_valid=0, key_code=0, overflow=0, counters 0, synchroniser flops high.
REQ-029 rst mid-DEBOUNCE/HELD SHALL discard the pending key; no push after release of rst until a fresh debounce.

Configuration
REQ-030 Macro KEYPAD_AUTOREPEAT_EN defined: in HELD, push latched code again REPEAT_DELAY cycles after first push, then every REPEAT_PERIOD cycles until leaving HELD; repeats obey REQ-025.
REQ-031 Macro undefined: exactly one push per press; REPEAT_* parameters unused, repeat counter absent.

Structure
REQ-032 Package keypad_pkg SHALL hold the FSM state enum, default parameter constants and code-width function.
REQ-033 FIFO SHALL be sub-module keypad_fifo (parameters DEPTH, W; push/pop/full/empty).

Verification (ROWS=COLS=4, DWELL=2, DEBOUNCE=20, FIFO_DEPTH=4, key_ready=1 unless stated)
REQ-034 Hold row2/col1 100 cycles -> exactly one key_valid pulse, code 9, 21 cycles after detection sample.
REQ-035 Row0/col3 low 5 cycles then high -> no push, scan resumes at row 1, key_valid stays 0.
REQ-036 key_ready=0, five distinct debounced presses codes 1,2,3,4,5 -> FIFO holds 1..4, overflow=1; draining yields 1,2,3,4 in order; clr_overflow -> 0.
REQ-037 Row1 col0 and col3 pressed together -> single code 4.
REQ-038 rst asserted at DEBOUNCE count 10 -> outputs at reset values same cycle; after rst release key still held -> push only after new full 20-cycle debounce.
REQ-039 FIFO_DEPTH=8, REPEAT_DELAY=100, REPEAT_PERIOD=50, key held 260 cycles past first push -> 5 pushes with macro, 1 without.
